led_fade_pwm: RTL and testbench

- Output stage directly downstream of driver_selector; drives the 8 board LEDs.
- Converts the hard on/off LED pattern into PWM brightness, so each LED ramps up and down smoothly ("heartbeat" glow) instead of switching abruptly.
- Runs on the 12 MHz system clock.
- led_in comes from the divided-clock domain and is synchronised internally.

---
 rtl/led_fade_pwm_if.sv | 14 +
 rtl/led_fade_pwm.sv | 90 +++++++++
 tb/tb_led_fade_pwm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_pwm_if.sv
// Bus bundle between driver_selector, the LED fade stage and the board pins.
// The master side drives the pattern and fade controls; the slave side returns the PWM pins and busy.
interface led_fade_pwm_if #(
   parameter int PWM_BITS = 8
);
   logic [7:0]          led_in;
   logic                fade_en;
   logic [PWM_BITS-1:0] max_level;
   logic [7:0]          led_out;
   logic                busy;

   modport master (output led_in, fade_en, max_level, input led_out, busy);
   modport slave  (input led_in, fade_en, max_level, output led_out, busy);
endinterface

// File: rtl/led_fade_pwm.sv
// Turns the on/off LED pattern into PWM brightness that ramps smoothly toward each target.
// Duty updates are taken only at PWM period boundaries so no period ever shows a torn pulse.
module led_fade_pwm #(
   parameter int PWM_BITS  = 8,
   parameter int STEP_DIV  = 12000,
   parameter int FADE_STEP = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   led_fade_pwm_if.slave  bus
);

   localparam int                    CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS-1:0]   LEVEL_MAX = '1;
   localparam logic [PWM_BITS:0]     STEP_EXT  = (PWM_BITS + 1)'(FADE_STEP);

   logic [7:0]                     sync1_q, sync2_q;
   logic [CNT_W-1:0]               tick_cnt_q, tick_cnt_d;
   logic                           tick;
   logic [PWM_BITS-1:0]            pwm_cnt_q;
   logic [7:0][PWM_BITS-1:0]       level_q, level_d;
   logic [7:0][PWM_BITS-1:0]       level_act_q, level_act_d;
   logic [7:0]                     led_out_q, led_out_d;
   logic                           busy_q, busy_d;

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   // Per-channel step toward target, clamped so a level can never pass its target or wrap.
   always_comb begin
      logic [PWM_BITS-1:0]        target;
      logic [PWM_BITS:0]          sum;
      logic signed [PWM_BITS:0]   diff;
      target      = '0;
      sum         = '0;
      diff        = '0;
      level_d     = level_q;
      level_act_d = level_act_q;
      led_out_d   = '0;
      busy_d      = 1'b0;
      for (int i = 0; i < 8; i++) begin
         target = sync2_q[i] ? bus.max_level : '0;
         sum    = {1'b0, level_q[i]} + STEP_EXT;
         diff   = $signed({1'b0, level_q[i]}) - $signed(STEP_EXT);
         if (level_q[i] != target) begin
            busy_d = 1'b1;
         end
         if (!bus.fade_en) begin
            level_d[i] = target;
         end else if (tick) begin
            if (level_q[i] < target) begin
               level_d[i] = (sum > {1'b0, target}) ? target : sum[PWM_BITS-1:0];
            end else if (level_q[i] > target) begin
               level_d[i] = (diff < $signed({1'b0, target})) ? target : diff[PWM_BITS-1:0];
            end
         end
         if (pwm_cnt_q == LEVEL_MAX) begin
            level_act_d[i] = level_q[i];
         end
         led_out_d[i] = (level_act_q[i] == LEVEL_MAX) || (pwm_cnt_q < level_act_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         tick_cnt_q  <= '0;
         pwm_cnt_q   <= '0;
         level_q     <= '0;
         level_act_q <= '0;
         led_out_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= bus.led_in;
         sync2_q     <= sync1_q;
         tick_cnt_q  <= tick_cnt_d;
         pwm_cnt_q   <= pwm_cnt_q + 1'b1;
         level_q     <= level_d;
         level_act_q <= level_act_d;
         led_out_q   <= led_out_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.led_out = led_out_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances (slow fade, and large-step clamp) checked every clock
// against an integer reference model, plus directed checks of reset, fade-up, reversal and bypass.
module tb_led_fade_pwm;

   logic       clk;
   logic       rst_n;
   logic [7:0] ledIn;
   logic       fadeEn;
   logic [7:0] maxLevel;
   logic       checkEn;
   int         checks;
   int         passes;

   led_fade_pwm_if #(.PWM_BITS(8)) ioA ();
   led_fade_pwm_if #(.PWM_BITS(8)) ioB ();

   assign ioA.led_in    = ledIn;
   assign ioA.fade_en   = fadeEn;
   assign ioA.max_level = maxLevel;
   assign ioB.led_in    = ledIn;
   assign ioB.fade_en   = fadeEn;
   assign ioB.max_level = maxLevel;

   led_fade_pwm #(.PWM_BITS(8), .STEP_DIV(8), .FADE_STEP(4)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ioA.slave)
   );

   led_fade_pwm #(.PWM_BITS(8), .STEP_DIV(1), .FADE_STEP(100)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ioB.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: plain integers per unit and channel.
   int         stepDiv  [2] = '{8, 1};
   int         fadeStep [2] = '{4, 100};
   int         lvl      [2][8];
   int         act      [2][8];
   logic [7:0] pipe1    [2];
   logic [7:0] pipe2    [2];
   int         cyc      [2];
   logic [7:0] mOut     [2];
   logic       mBusy    [2];

   task automatic modelClear();
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 8; i++) begin
            lvl[u][i] = 0;
            act[u][i] = 0;
         end
         pipe1[u] = '0;
         pipe2[u] = '0;
         cyc[u]   = 0;
         mOut[u]  = '0;
         mBusy[u] = 1'b0;
      end
   endtask

   task automatic modelStep(input int u, input logic [7:0] led, input logic fe, input int ml);
      int         tgt [8];
      int         phase;
      bit         tk;
      logic [7:0] o;
      logic       b;
      phase = cyc[u] % 256;
      tk    = (cyc[u] % stepDiv[u]) == stepDiv[u] - 1;
      o     = '0;
      b     = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tgt[i] = pipe2[u][i] ? ml : 0;
         o[i]   = (act[u][i] == 255) || (phase < act[u][i]);
         if (lvl[u][i] != tgt[i]) b = 1'b1;
         if (phase == 255) act[u][i] = lvl[u][i];
         if (!fe) begin
            lvl[u][i] = tgt[i];
         end else if (tk) begin
            if (lvl[u][i] < tgt[i])
               lvl[u][i] = (lvl[u][i] + fadeStep[u] > tgt[i]) ? tgt[i] : lvl[u][i] + fadeStep[u];
            else if (lvl[u][i] > tgt[i])
               lvl[u][i] = (lvl[u][i] - fadeStep[u] < tgt[i]) ? tgt[i] : lvl[u][i] - fadeStep[u];
         end
      end
      pipe2[u] = pipe1[u];
      pipe1[u] = led;
      cyc[u]   = cyc[u] + 1;
      mOut[u]  = o;
      mBusy[u] = b;
   endtask

   initial begin
      modelClear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            modelClear();
         end else begin
            modelStep(0, ledIn, fadeEn, int'(maxLevel));
            modelStep(1, ledIn, fadeEn, int'(maxLevel));
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      else
         passes++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            checkOutput("A.led_out", 32'(ioA.led_out), 32'(mOut[0]));
            checkOutput("A.busy",    32'(ioA.busy),    32'(mBusy[0]));
            checkOutput("B.led_out", 32'(ioB.led_out), 32'(mOut[1]));
            checkOutput("B.busy",    32'(ioB.busy),    32'(mBusy[1]));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] led, input logic fe, input logic [7:0] ml);
      @(posedge clk);
      #2;
      ledIn    = led;
      fadeEn   = fe;
      maxLevel = ml;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic countHighA(output int highs [8]);
      for (int i = 0; i < 8; i++) highs[i] = 0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) highs[i] += int'(ioA.led_out[i]);
      end
   endtask

   initial begin
      int  highs [8];
      bit  seen;
      checks   = 0;
      passes   = 0;
      checkEn  = 1'b0;
      rst_n    = 1'b0;
      ledIn    = 8'hFF;
      fadeEn   = 1'b1;
      maxLevel = 8'd255;

      waitCycles(4);
      @(negedge clk);
      checkOutput("reset.led_out", 32'(ioA.led_out), 32'h0);
      checkOutput("reset.busy",    32'(ioA.busy),    32'h0);
      checkEn = 1'b1;

      applyStimulus(8'h00, 1'b1, 8'd255);
      rst_n = 1'b1;
      waitCycles(300);

      // Fade up channel 0 to full brightness.
      applyStimulus(8'h01, 1'b1, 8'd255);
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(negedge clk);
         if (ioA.busy) seen = 1'b1;
      end
      checkOutput("fadeUp.busyRise", 32'(seen), 32'h1);
      waitCycles(1000);
      countHighA(highs);
      checkOutput("fadeUp.bit0High", 32'(highs[0]), 32'd256);
      checkOutput("fadeUp.bit1High", 32'(highs[1]), 32'd0);
      checkOutput("fadeUp.busy",     32'(ioA.busy), 32'h0);

      // Reverse partway up the ramp.
      applyStimulus(8'h00, 1'b1, 8'd255);
      waitCycles(1000);
      applyStimulus(8'h01, 1'b1, 8'd255);
      waitCycles(260);
      applyStimulus(8'h00, 1'b1, 8'd255);
      waitCycles(600);
      countHighA(highs);
      checkOutput("reverse.bit0High", 32'(highs[0]), 32'd0);
      checkOutput("reverse.busy",     32'(ioA.busy), 32'h0);

      // Bypass mode snaps levels to target.
      applyStimulus(8'hA5, 1'b0, 8'd128);
      waitCycles(2 + 256 + 1 + 4);
      countHighA(highs);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("bypass.bit%0dHigh", i), 32'(highs[i]), ((8'hA5 >> i) & 1) != 0 ? 32'd128 : 32'd0);

      // Clamp scenario on instance B (large step, tick every clock).
      applyStimulus(8'h00, 1'b1, 8'd250);
      waitCycles(300);
      applyStimulus(8'h01, 1'b1, 8'd250);
      waitCycles(600);
      applyStimulus(8'h00, 1'b1, 8'd250);
      waitCycles(600);

      // Randomized phase, with one asynchronous reset landing mid-fade.
      for (int it = 0; it < 25; it++) begin
         logic [7:0] ml;
         ml = 8'($urandom);
         if (it % 7 == 3) ml = 8'd255;
         if (it % 9 == 5) ml = 8'd0;
         applyStimulus(8'($urandom), ($urandom_range(0, 3) != 0), ml);
         waitCycles($urandom_range(1, 400));
         if (it == 12) begin
            applyStimulus(8'hFF, 1'b1, 8'd255);
            waitCycles(400);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("asyncReset.led_out", 32'(ioA.led_out), 32'h0);
            checkOutput("asyncReset.busy",    32'(ioA.busy),    32'h0);
            waitCycles(3);
            #2;
            rst_n = 1'b1;
         end
      end
      waitCycles(50);

      checkEn = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
